// File: rtl/digit_scan_ctrl_pkg.sv
// Shared display types and constants for the front-panel digit scanner.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package display_pkg;

  typedef logic [3:0] digit_t;

  localparam int     KEY_SEL_DEFAULT = 11;
  // Value that counts as a leading zero for blanking purposes.
  localparam digit_t DIGIT_BLANK     = 4'h0;

  // One-hot decode of a digit index; callers truncate to their digit count.
  function automatic logic [7:0] onehot_sel(input logic [2:0] idx);
    onehot_sel = 8'b1 << idx;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Bundle of write port, keypad inputs and scan outputs of the digit scanner.
// Latency: n/a (wires only).
// Backpressure: none; all signals are plain levels/strobes.
// Ports: master drives wr_*/num/kphit/blank_lz, slave drives ct/digit_*/edit_mode/frame_tick.
interface digit_scan_ctrl_if
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  localparam int AW = $clog2(NUM_DIGITS);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  digit_t                wr_data;
  logic [3:0]            num;
  logic                  kphit;
  logic                  blank_lz;

  logic [NUM_DIGITS-1:0] ct;
  digit_t                digit_val;
  logic [AW-1:0]         digit_idx;
  logic                  edit_mode;
  logic                  frame_tick;

  modport master (
    output wr_en, wr_addr, wr_data, num, kphit, blank_lz,
    input  ct, digit_val, digit_idx, edit_mode, frame_tick
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, num, kphit, blank_lz,
    output ct, digit_val, digit_idx, edit_mode, frame_tick
  );

endinterface

// File: rtl/digit_scan_ctrl_prescaler.sv
// Slot prescaler and digit pointer; flags each slot end and each full scan frame.
// Latency: slot_tick combinational from count; frame_tick registered, high the cycle after wrap.
// Backpressure: none; free-running.
// Ports: clk, reset_n in; ptr (current digit), slot_tick, frame_tick out.
module scan_prescaler #(
  parameter int DIV_COUNT  = 50000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  output logic [$clog2(NUM_DIGITS)-1:0] ptr,
  output logic                          slot_tick,
  output logic                          frame_tick
);

  localparam int PW = $clog2(DIV_COUNT);
  localparam int AW = $clog2(NUM_DIGITS);

  logic [PW-1:0] r_cnt;
  logic [AW-1:0] r_ptr;
  logic          r_frame_tick;
  logic          w_last_digit;

  assign slot_tick    = (r_cnt == PW'(DIV_COUNT - 1));
  assign w_last_digit = (r_ptr == AW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt        <= '0;
      r_ptr        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= slot_tick & w_last_digit;
      if (slot_tick) begin
        r_cnt <= '0;
        r_ptr <= w_last_digit ? '0 : r_ptr + AW'(1);
      end else begin
        r_cnt <= r_cnt + PW'(1);
      end
    end
  end

  assign ptr        = r_ptr;
  assign frame_tick = r_frame_tick;

endmodule

// File: rtl/digit_scan_ctrl.sv
// Multiplexed seven-segment scan controller: digit buffer, leading-zero blanking, edit-mode blink.
// Latency: outputs registered, 1 cycle after pointer/buffer/mode change.
// Backpressure: none; writes and key presses are accepted every cycle.
// Ports: clk, reset_n (async, active low); bus = write port, keypad and scan outputs.
module digit_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV_COUNT    = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int KEY_SEL      = KEY_SEL_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  digit_scan_ctrl_if.slave  bus
);

  localparam int AW = $clog2(NUM_DIGITS);
  localparam int BW = $clog2(BLINK_FRAMES) + 1;

  logic [AW-1:0]         w_ptr;
  logic                  w_slot_tick;
  logic                  w_frame_tick;
  logic                  w_frame_wrap;
  logic                  w_key_rise;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_blank;
  logic                  w_gate;

  digit_t                r_buf [NUM_DIGITS];
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_phase;
  logic                  r_edit_mode;
  logic                  r_kphit_q;
  logic [NUM_DIGITS-1:0] r_ct;
  digit_t                r_digit_val;
  logic [AW-1:0]         r_digit_idx;

  scan_prescaler #(
    .DIV_COUNT  (DIV_COUNT),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .ptr        (w_ptr),
    .slot_tick  (w_slot_tick),
    .frame_tick (w_frame_tick)
  );

  // The slot tick on the last digit is the edge where the pointer wraps.
  assign w_frame_wrap = w_slot_tick & (w_ptr == AW'(NUM_DIGITS - 1));
  assign w_key_rise   = bus.kphit & ~r_kphit_q;

  // Walk from the MSD down: a digit is blanked while every digit at or above it is zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_buf[i] == DIGIT_BLANK);
      if (i > 0) begin
        w_blank[i] = bus.blank_lz & w_zero_run;
      end
    end
  end

  // Enable is dropped for blanked digits and for the MSD during the off half of the blink.
  assign w_gate = w_blank[w_ptr] |
                  (r_edit_mode & r_blink_phase & (w_ptr == AW'(NUM_DIGITS - 1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_buf[i] <= '0;
      end
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_edit_mode   <= 1'b0;
      r_kphit_q     <= 1'b0;
      r_ct          <= '0;
      r_digit_val   <= '0;
      r_digit_idx   <= '0;
    end else begin
      if (bus.wr_en && (32'(bus.wr_addr) < NUM_DIGITS)) begin
        r_buf[bus.wr_addr] <= bus.wr_data;
      end

      r_kphit_q <= bus.kphit;
      if (w_key_rise && (bus.num == 4'(KEY_SEL))) begin
        r_edit_mode <= ~r_edit_mode;
      end

      if (w_frame_wrap) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end

      r_digit_idx <= w_ptr;
      r_digit_val <= r_buf[w_ptr];
      r_ct        <= w_gate ? '0 : NUM_DIGITS'(onehot_sel(3'(w_ptr)));
    end
  end

  assign bus.ct         = r_ct;
  assign bus.digit_val  = r_digit_val;
  assign bus.digit_idx  = r_digit_idx;
  assign bus.edit_mode  = r_edit_mode;
  assign bus.frame_tick = w_frame_tick;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
`timescale 1ns/1ps
module tb_digit_scan_ctrl;
  import display_pkg::*;

  localparam int N0 = 4, D0 = 4, B0 = 2;
  localparam int N1 = 3, D1 = 2, B1 = 1;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] num;
  logic       kphit;
  logic       blank_lz;

  digit_scan_ctrl_if #(.NUM_DIGITS(N0)) bus0();
  digit_scan_ctrl_if #(.NUM_DIGITS(N1)) bus1();

  assign bus0.wr_en = wr_en;  assign bus0.wr_addr = wr_addr; assign bus0.wr_data = wr_data;
  assign bus0.num = num;      assign bus0.kphit = kphit;     assign bus0.blank_lz = blank_lz;
  assign bus1.wr_en = wr_en;  assign bus1.wr_addr = wr_addr; assign bus1.wr_data = wr_data;
  assign bus1.num = num;      assign bus1.kphit = kphit;     assign bus1.blank_lz = blank_lz;

  digit_scan_ctrl #(.NUM_DIGITS(N0), .DIV_COUNT(D0), .BLINK_FRAMES(B0), .KEY_SEL(11))
    dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  digit_scan_ctrl #(.NUM_DIGITS(N1), .DIV_COUNT(D1), .BLINK_FRAMES(B1), .KEY_SEL(11))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Model: time-based view of the scan (edge count since reset) plus buffer and mode.
  int         m      [2];
  logic [3:0] mbuf   [2][8];
  bit         medit  [2];
  bit         mkprev [2];
  logic [7:0] e_ct   [2];
  logic [3:0] e_val  [2];
  int         e_idx  [2];
  bit         e_edit [2];
  bit         e_ft   [2];

  function automatic int cfg_n(int d);   return (d == 0) ? N0 : N1; endfunction
  function automatic int cfg_div(int d); return (d == 0) ? D0 : D1; endfunction
  function automatic int cfg_bf(int d);  return (d == 0) ? B0 : B1; endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m[d] = 0; medit[d] = 1'b0; mkprev[d] = 1'b0;
      for (int j = 0; j < 8; j++) mbuf[d][j] = 4'd0;
      e_ct[d] = 8'd0; e_val[d] = 4'd0; e_idx[d] = 0; e_edit[d] = 1'b0; e_ft[d] = 1'b0;
    end
  endtask

  // Predict outputs after the next clock edge from the current inputs, then apply the edge.
  task automatic model_step(int d);
    int n, nd, dv, bf, ptr, frames;
    bit phase, blanked, suppress;
    n = m[d]; nd = cfg_n(d); dv = cfg_div(d); bf = cfg_bf(d);
    ptr    = (n / dv) % nd;
    frames = n / (dv * nd);
    phase  = ((frames / bf) % 2) == 1;
    blanked = 1'b0;
    if (blank_lz && ptr > 0) begin
      blanked = 1'b1;
      for (int j = ptr; j < nd; j++) if (mbuf[d][j] != 4'd0) blanked = 1'b0;
    end
    suppress = medit[d] && (ptr == nd - 1) && phase;
    e_idx[d] = ptr;
    e_val[d] = mbuf[d][ptr];
    e_ct[d]  = (blanked || suppress) ? 8'd0 : (8'd1 << ptr);
    if (wr_en && int'(wr_addr) < nd) mbuf[d][wr_addr] = wr_data;
    if (kphit && !mkprev[d] && num == 4'd11) medit[d] = !medit[d];
    mkprev[d] = kphit;
    m[d]      = n + 1;
    e_edit[d] = medit[d];
    e_ft[d]   = (m[d] % (dv * nd)) == 0;
  endtask

  task automatic check_all();
    chk("ct0",   32'(bus0.ct),         32'(e_ct[0]));
    chk("val0",  32'(bus0.digit_val),  32'(e_val[0]));
    chk("idx0",  32'(bus0.digit_idx),  32'(e_idx[0]));
    chk("edit0", 32'(bus0.edit_mode),  32'(e_edit[0]));
    chk("ft0",   32'(bus0.frame_tick), 32'(e_ft[0]));
    chk("ct1",   32'(bus1.ct),         32'(e_ct[1]));
    chk("val1",  32'(bus1.digit_val),  32'(e_val[1]));
    chk("idx1",  32'(bus1.digit_idx),  32'(e_idx[1]));
    chk("edit1", 32'(bus1.edit_mode),  32'(e_edit[1]));
    chk("ft1",   32'(bus1.frame_tick), 32'(e_ft[1]));
  endtask

  task automatic cyc();
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  // Assert reset asynchronously (between edges), check outputs cleared, release on a falling edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_ct0",   32'(bus0.ct), 32'd0);
    chk("rst_val0",  32'(bus0.digit_val), 32'd0);
    chk("rst_edit0", 32'(bus0.edit_mode), 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int c1000, c0100, c0010, c0001, c_oor;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 4'd0; num = 4'd0; kphit = 1'b0; blank_lz = 1'b0;
    #1;
    do_reset();

    // First edge after release enables digit 0.
    cyc();
    chk("first_ct0", 32'(bus0.ct), 32'd1);
    chk("first_ct1", 32'(bus1.ct), 32'd1);

    // Scan order with buffer 1,2,3,4 (dut1 sees addr 3 as out of range).
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = 4'(i + 1);
      cyc();
    end
    wr_en = 1'b0;
    while (m[0] % 16 != 0) cyc();
    c_oor = 0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("scan_ct",  32'(bus0.ct), 32'(1 << ((k - 1) / 4)));
      chk("scan_val", 32'(bus0.digit_val), 32'((k - 1) / 4 + 1));
      chk("scan_ft",  32'(bus0.frame_tick), (k == 16) ? 32'd1 : 32'd0);
      if (bus1.digit_val == 4'd4) c_oor++;
    end
    chk("oor_write_ignored", 32'(c_oor), 32'd0);

    // Leading-zero blanking: MSD..LSD = 0,0,7,0.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = (i == 1) ? 4'd7 : 4'd0;
      cyc();
    end
    wr_en = 1'b0; blank_lz = 1'b1;
    cyc(); cyc();
    c1000 = 0; c0100 = 0; c0010 = 0; c0001 = 0;
    repeat (16) begin
      cyc();
      if (bus0.ct == 4'b1000) c1000++;
      if (bus0.ct == 4'b0100) c0100++;
      if (bus0.ct == 4'b0010) c0010++;
      if (bus0.ct == 4'b0001) c0001++;
    end
    chk("blank_1000", 32'(c1000), 32'd0);
    chk("blank_0100", 32'(c0100), 32'd0);
    chk("blank_0010", 32'(c0010), 32'd4);
    chk("blank_0001", 32'(c0001), 32'd4);
    blank_lz = 1'b0;
    cyc();
    c1000 = 0; c0100 = 0;
    repeat (16) begin
      cyc();
      if (bus0.ct == 4'b1000) c1000++;
      if (bus0.ct == 4'b0100) c0100++;
    end
    chk("noblank_1000", 32'(c1000), 32'd4);
    chk("noblank_0100", 32'(c0100), 32'd4);

    // Edit mode: press, hold, other key, blink, second press.
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'd8;
    cyc();
    wr_en = 1'b0; kphit = 1'b1; num = 4'd11;
    cyc();
    chk("edit_on", 32'(bus0.edit_mode), 32'd1);
    repeat (5) cyc();
    chk("edit_held", 32'(bus0.edit_mode), 32'd1);
    kphit = 1'b0; cyc();
    kphit = 1'b1; num = 4'd5; cyc(); cyc();
    chk("edit_other_key", 32'(bus0.edit_mode), 32'd1);
    kphit = 1'b0; cyc();
    c1000 = 0;
    repeat (64) begin
      cyc();
      if (bus0.ct == 4'b1000) c1000++;
    end
    chk("blink_msd_count", 32'(c1000), 32'd8);
    kphit = 1'b1; num = 4'd11; cyc();
    chk("edit_off", 32'(bus0.edit_mode), 32'd0);
    kphit = 1'b0; cyc();

    // Write to the displayed digit is visible on the next cycle.
    while (m[0] % 16 != 8) cyc();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd9;
    cyc();
    wr_en = 1'b0;
    cyc();
    chk("wr_hazard_val", 32'(bus0.digit_val), 32'd9);
    chk("wr_hazard_idx", 32'(bus0.digit_idx), 32'd2);

    // Key rise on the slot tick that wraps the pointer.
    while (m[0] % 16 != 15) cyc();
    kphit = 1'b1; num = 4'd11;
    cyc();
    chk("wrap_edit", 32'(bus0.edit_mode), 32'd1);
    chk("wrap_ft",   32'(bus0.frame_tick), 32'd1);
    kphit = 1'b0;
    cyc();
    chk("wrap_idx",  32'(bus0.digit_idx), 32'd0);

    // Async reset while pointer is on digit 2, edit mode set.
    while (m[0] % 16 != 10) cyc();
    do_reset();
    cyc();
    chk("post_rst_ct0",  32'(bus0.ct), 32'd1);
    chk("post_rst_val0", 32'(bus0.digit_val), 32'd0);
    repeat (16) cyc();

    // Randomised traffic, with one more reset midway.
    for (int it = 0; it < 3000; it++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) kphit = ~kphit;
      num = ($urandom_range(0, 1) == 0) ? 4'd11 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      if (it == 1500) do_reset();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
